ex_mem_reg: RTL

- EX/MEM pipeline register directly downstream of the EX-stage ALU.
- Captures the ALU result, the zero flag, store data, destination register and the MEM/WB control bits.
- Resolves beq in the MEM stage and drives the PC redirect and flush requests back to IF/ID and ID/EX.
- Supports a hold (stall) from the hazard unit, an external flush, and self-squash of wrong-path instructions.

---
 rtl/ex_mem_reg.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register. Captures the EX-stage results and MEM/WB controls,
// resolves beq in MEM and drives the PC redirect / flush back to the front end.
module ex_mem_reg #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               ex_valid,
    input  logic [XLEN-1:0]    ex_alu_res,
    input  logic               ex_zero,
    input  logic [XLEN-1:0]    ex_rs2_data,
    input  logic [RADDR_W-1:0] ex_rd,
    input  logic [XLEN-1:0]    ex_branch_target,
    input  logic               ex_branch,
    input  logic               ex_mem_read,
    input  logic               ex_mem_write,
    input  logic               ex_reg_write,
    input  logic               ex_mem_to_reg,
    output logic               mem_valid,
    output logic [XLEN-1:0]    mem_alu_res,
    output logic [XLEN-1:0]    mem_rs2_data,
    output logic [RADDR_W-1:0] mem_rd,
    output logic               mem_mem_read,
    output logic               mem_mem_write,
    output logic               mem_reg_write,
    output logic               mem_mem_to_reg,
    output logic               pc_src,
    output logic [XLEN-1:0]    pc_branch_target,
    output logic               flush_req
);

    logic               valid_q, valid_d;
    logic               taken_q, taken_d;
    logic [XLEN-1:0]    alu_res_q, alu_res_d;
    logic [XLEN-1:0]    rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]    target_q, target_d;
    logic [RADDR_W-1:0] rd_q, rd_d;
    logic               mem_read_q, mem_read_d;
    logic               mem_write_q, mem_write_d;
    logic               reg_write_q, reg_write_d;
    logic               mem_to_reg_q, mem_to_reg_d;
    logic               squash;

    // A pending taken branch squashes the wrong-path instruction now leaving EX.
    assign squash = flush | pc_src;

    // Next state: squash beats stall, stall beats load.
    always_comb begin
        valid_d      = valid_q;
        taken_d      = taken_q;
        alu_res_d    = alu_res_q;
        rs2_data_d   = rs2_data_q;
        target_d     = target_q;
        rd_d         = rd_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        if (squash) begin
            valid_d      = 1'b0;
            taken_d      = 1'b0;
            alu_res_d    = '0;
            rs2_data_d   = '0;
            target_d     = '0;
            rd_d         = '0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            reg_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
        end else if (!stall) begin
            valid_d      = ex_valid;
            taken_d      = ex_valid & ex_branch & ex_zero;
            alu_res_d    = ex_alu_res;
            rs2_data_d   = ex_rs2_data;
            target_d     = ex_branch_target;
            rd_d         = ex_rd;
            mem_read_d   = ex_mem_read;
            mem_write_d  = ex_mem_write;
            reg_write_d  = ex_reg_write;
            mem_to_reg_d = ex_mem_to_reg;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            taken_q      <= 1'b0;
            alu_res_q    <= '0;
            rs2_data_q   <= '0;
            target_q     <= '0;
            rd_q         <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            taken_q      <= taken_d;
            alu_res_q    <= alu_res_d;
            rs2_data_q   <= rs2_data_d;
            target_q     <= target_d;
            rd_q         <= rd_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
        end
    end

    // Outputs; controls gated by valid so a bubble never writes anything.
    always_comb begin
        mem_valid        = valid_q;
        mem_alu_res      = alu_res_q;
        mem_rs2_data     = rs2_data_q;
        mem_rd           = rd_q;
        mem_mem_read     = mem_read_q & valid_q;
        mem_mem_write    = mem_write_q & valid_q;
        mem_reg_write    = reg_write_q & valid_q;
        mem_mem_to_reg   = mem_to_reg_q & valid_q;
        pc_src           = taken_q & valid_q;
        pc_branch_target = target_q;
        flush_req        = taken_q & valid_q;
    end

endmodule
